// File: rtl/dwt_line_aligner_pkg.sv
// Types shared by the column-DWT stream blocks.
package dwt_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        PASS
    } state_t;

    // Priming lines emitted by the two cascaded 9/7 lifting stages.
    localparam int unsigned DefaultSkipLines = 4;

endpackage

// File: rtl/dwt_line_aligner_if.sv
// Upstream (s_*) and downstream (m_*) stream handshake of the line aligner.
interface dwt_line_aligner_if #(
    parameter int unsigned Width = 32
);
    logic             s_valid;
    logic             s_ready;
    logic             s_sof;
    logic             s_eol;
    logic [Width-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_sof;
    logic             m_eol;
    logic             m_eof;
    logic [Width-1:0] m_data;

    modport master (
        output s_valid, s_sof, s_eol, s_data, m_ready,
        input  s_ready, m_valid, m_sof, m_eol, m_eof, m_data
    );

    modport slave (
        input  s_valid, s_sof, s_eol, s_data, m_ready,
        output s_ready, m_valid, m_sof, m_eol, m_eof, m_data
    );
endinterface

// File: rtl/dwt_line_aligner_skid.sv
// Two-entry registered ready/valid buffer: output register plus one skid slot.
module stream_skid_buffer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);
    logic             out_valid_q;
    logic             skid_valid_q;
    logic [Width-1:0] out_data_q;
    logic [Width-1:0] skid_data_q;

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else if (out_ready_i || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_valid_i;
                if (in_valid_i) out_data_q <= in_data_i;
            end
        end else if (in_valid_i && !skid_valid_q) begin
            // Output stalled: park the beat so upstream ready can stay registered.
            skid_valid_q <= 1'b1;
            skid_data_q  <= in_data_i;
        end
    end
endmodule

// File: rtl/dwt_line_aligner.sv
// Drops the lifting pipeline's priming lines each frame, regenerates SOF,
// marks EOF on the last kept beat and flags framing errors.
module dwt_line_aligner
    import dwt_stream_pkg::*;
#(
    parameter  int unsigned DataWidth    = 16,
    parameter  int unsigned Channels     = 1,
    parameter  int unsigned MaxSkipLines = 7,
    parameter  int unsigned MaxHeight    = 512,
    localparam int unsigned Width        = Channels * 2 * DataWidth,
    localparam int unsigned LineW        = $clog2(MaxSkipLines + 1),
    localparam int unsigned KeptW        = $clog2(MaxHeight + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [LineW-1:0]     cfg_skip_lines_i,
    input  logic [KeptW-1:0]     cfg_height_i,
    dwt_line_aligner_if.slave    bus,
    output logic                 err_o
);
    state_t           state_q;
    logic [LineW-1:0] line_cnt_q;
    logic [LineW-1:0] skip_q;
    logic [KeptW-1:0] kept_cnt_q;
    logic [KeptW-1:0] height_q;
    logic             first_q;
    logic             err_q;
    logic             rdy_en_q;

    logic             skid_in_ready;
    logic             accept;
    logic             push_valid;
    logic             push_sof;
    logic             push_eof;
    logic [KeptW-1:0] height_cfg;

    assign height_cfg  = (cfg_height_i == '0) ? KeptW'(1) : cfg_height_i;
    // Dropping beats in SKIP never needs buffer space; anything that may forward does.
    assign bus.s_ready = rdy_en_q & (skid_in_ready | ((state_q == SKIP) & ~bus.s_sof));
    assign accept      = bus.s_valid & bus.s_ready;
    assign err_o       = err_q;

    always_comb begin
        push_valid = 1'b0;
        push_sof   = 1'b0;
        push_eof   = 1'b0;
        if (accept) begin
            if (bus.s_sof) begin
                push_valid = (cfg_skip_lines_i == '0);
                push_sof   = 1'b1;
                push_eof   = bus.s_eol & (height_cfg == KeptW'(1));
            end else if (state_q == PASS) begin
                push_valid = 1'b1;
                push_sof   = first_q;
                push_eof   = bus.s_eol & (kept_cnt_q == height_q - KeptW'(1));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            line_cnt_q <= '0;
            skip_q     <= '0;
            kept_cnt_q <= '0;
            height_q   <= '0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (accept) begin
                if (bus.s_sof) begin
                    // A SOF anywhere restarts the frame; outside IDLE it aborts one.
                    if (state_q != IDLE) err_q <= 1'b1;
                    skip_q     <= cfg_skip_lines_i;
                    height_q   <= height_cfg;
                    line_cnt_q <= '0;
                    kept_cnt_q <= '0;
                    first_q    <= (cfg_skip_lines_i != '0);
                    if (cfg_skip_lines_i == '0) begin
                        if (push_eof) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= PASS;
                            if (bus.s_eol) kept_cnt_q <= KeptW'(1);
                        end
                    end else if (bus.s_eol && cfg_skip_lines_i == LineW'(1)) begin
                        state_q <= PASS;
                    end else begin
                        state_q <= SKIP;
                        if (bus.s_eol) line_cnt_q <= LineW'(1);
                    end
                end else begin
                    case (state_q)
                        IDLE: err_q <= 1'b1;
                        SKIP: begin
                            if (bus.s_eol) begin
                                if (line_cnt_q + LineW'(1) == skip_q) begin
                                    line_cnt_q <= '0;
                                    state_q    <= PASS;
                                end else begin
                                    line_cnt_q <= line_cnt_q + LineW'(1);
                                end
                            end
                        end
                        PASS: begin
                            first_q <= 1'b0;
                            if (push_eof) begin
                                state_q    <= IDLE;
                                kept_cnt_q <= '0;
                            end else if (bus.s_eol) begin
                                kept_cnt_q <= kept_cnt_q + KeptW'(1);
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    stream_skid_buffer #(
        .Width (Width + 3)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (push_valid),
        .in_ready_o  (skid_in_ready),
        .in_data_i   ({push_eof, bus.s_eol, push_sof, bus.s_data}),
        .out_valid_o (bus.m_valid),
        .out_ready_i (bus.m_ready),
        .out_data_o  ({bus.m_eof, bus.m_eol, bus.m_sof, bus.m_data})
    );
endmodule

// File: tb/tb_dwt_line_aligner.sv
// Directed self-checking bench for dwt_line_aligner (Channels=1, 16-bit coefficients).
module tb_dwt_line_aligner;
    import dwt_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cfg_skip = '0;
    logic [9:0]  cfg_height = '0;
    logic        err;
    int          tests = 0;
    int          fails = 0;
    logic        rand_ready = 1'b0;
    logic        stall = 1'b0;
    logic        chk_ready = 1'b0;
    logic [31:0] dcnt = '0;
    logic [34:0] got_q[$];
    logic [34:0] exp_q[$];
    logic [34:0] hold = '0;
    logic        hold_v = 1'b0;

    dwt_line_aligner_if #(.Width(32)) bus ();

    dwt_line_aligner #(
        .DataWidth(16), .Channels(1), .MaxSkipLines(7), .MaxHeight(512)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cfg_skip_lines_i (cfg_skip),
        .cfg_height_i     (cfg_height),
        .bus              (bus),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        bus.m_ready = stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Output monitor: capture transfers, check stall stability and ready/full relation.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                tests++;
                assert (bus.m_valid === 1'b1 && {bus.m_sof, bus.m_eol, bus.m_eof, bus.m_data} === hold)
                else begin
                    fails++;
                    $error("FAIL stall_stable: observed %0h expected %0h",
                           {bus.m_sof, bus.m_eol, bus.m_eof, bus.m_data}, hold);
                end
            end
            if (chk_ready && bus.s_ready === 1'b0) begin
                tests++;
                assert (bus.m_valid === 1'b1)
                else begin
                    fails++;
                    $error("FAIL ready_low_not_full: observed m_valid %0b expected 1", bus.m_valid);
                end
            end
            if (bus.m_valid && bus.m_ready) got_q.push_back({bus.m_sof, bus.m_eol, bus.m_eof, bus.m_data});
            hold_v = bus.m_valid & ~bus.m_ready;
            hold   = {bus.m_sof, bus.m_eol, bus.m_eof, bus.m_data};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic sof, input logic eol, input logic [31:0] d);
        int   n = 0;
        logic acc = 1'b0;
        bus.s_valid = 1'b1; bus.s_sof = sof; bus.s_eol = eol; bus.s_data = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_eol = 1'b0;
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    endtask

    // Model of a well-formed frame: kept lines are [skip, skip+max(height,1)).
    task automatic send_frame(input int skip, input int height, input int lines, input int bpl,
                              input bit chk_lat);
        int   h;
        logic sof, eol;
        h = (height == 0) ? 1 : height;
        cfg_skip = 3'(skip);
        cfg_height = 10'(height);
        for (int l = 0; l < lines; l++) begin
            for (int b = 0; b < bpl; b++) begin
                sof = (l == 0 && b == 0);
                eol = (b == bpl - 1);
                if (l >= skip && l < skip + h)
                    exp_q.push_back({(l == skip && b == 0), eol, (eol && l == skip + h - 1), dcnt});
                send(sof, eol, dcnt);
                if (chk_lat && sof) begin
                    chk("sof_latency_valid", 64'(bus.m_valid), 64'd1);
                    chk("sof_latency_sof", 64'(bus.m_sof), 64'd1);
                    chk("sof_latency_data", 64'(bus.m_data), 64'(dcnt));
                end
                dcnt++;
            end
        end
    endtask

    task automatic drain_compare(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk($sformatf("%s_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    function automatic logic [15:0] mask(input int bp);
        logic [15:0] m = '0;
        for (int i = 0; i < got_q.size() && i < 16; i++) m[i] = got_q[i][bp];
        return m;
    endfunction

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        chk_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_ready = 1'b1;
    endtask

    initial begin
        bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_eol = 1'b0; bus.s_data = '0;
        #1;
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_flags", 64'({bus.m_sof, bus.m_eol, bus.m_eof}), 64'd0);
        chk("rst_m_data", 64'(bus.m_data), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        pulse_reset();
        chk("post_rst_s_ready", 64'(bus.s_ready), 64'd1);

        // Test 1: skip 4, height 3, 4-beat lines, 7 lines, ready always high.
        send_frame(DefaultSkipLines, 3, 7, 4, 1'b0);
        drain_compare("t1");
        chk("t1_first_data", 64'(got_q[0][31:0]), 64'd16);
        chk("t1_sof_mask", 64'(mask(34)), 64'h0001);
        chk("t1_eol_mask", 64'(mask(33)), 64'h0888);
        chk("t1_eof_mask", 64'(mask(32)), 64'h0800);
        chk("t1_err", 64'(err), 64'd0);
        clear_q();

        // Test 2: skip 0 forwards the SOF beat one cycle after acceptance.
        send_frame(0, 2, 2, 2, 1'b1);
        drain_compare("t2");
        chk("t2_sof_mask", 64'(mask(34)), 64'h0001);
        chk("t2_eol_mask", 64'(mask(33)), 64'h000A);
        chk("t2_eof_mask", 64'(mask(32)), 64'h0008);
        clear_q();

        // Test 3: test 1 stimulus under random downstream back-pressure.
        rand_ready = 1'b1;
        send_frame(4, 3, 7, 4, 1'b0);
        drain_compare("t3");
        chk("t3_eof_mask", 64'(mask(32)), 64'h0800);
        rand_ready = 1'b0;
        clear_q();

        // Test 4: back-to-back frames, skip 4 then skip 2.
        send_frame(4, 3, 7, 4, 1'b0);
        send_frame(2, 2, 4, 2, 1'b0);
        drain_compare("t4");
        chk("t4_sof_mask", 64'(mask(34)), 64'h1001);
        chk("t4_eof_mask", 64'(mask(32)), 64'h8800);
        chk("t4_err", 64'(err), 64'd0);
        clear_q();

        // Test 5: new SOF after one kept line of a height-3 frame.
        cfg_skip = 3'd2; cfg_height = 10'd3;
        send(1'b1, 1'b0, dcnt); dcnt++;
        send(1'b0, 1'b1, dcnt); dcnt++;
        send(1'b0, 1'b0, dcnt); dcnt++;
        send(1'b0, 1'b1, dcnt); dcnt++;
        exp_q.push_back({3'b100, dcnt}); send(1'b0, 1'b0, dcnt); dcnt++;
        exp_q.push_back({3'b010, dcnt}); send(1'b0, 1'b1, dcnt); dcnt++;
        exp_q.push_back({3'b000, dcnt}); send(1'b0, 1'b0, dcnt); dcnt++;
        chk("t5_err_before", 64'(err), 64'd0);
        cfg_skip = 3'd1; cfg_height = 10'd1;
        send(1'b1, 1'b0, dcnt); dcnt++;
        chk("t5_err_after", 64'(err), 64'd1);
        send(1'b0, 1'b1, dcnt); dcnt++;
        exp_q.push_back({3'b100, dcnt}); send(1'b0, 1'b0, dcnt); dcnt++;
        exp_q.push_back({3'b011, dcnt}); send(1'b0, 1'b1, dcnt); dcnt++;
        drain_compare("t5");
        chk("t5_eof_mask", 64'(mask(32)), 64'h0010);
        clear_q();

        // Test 6: stray IDLE beat sets err; reset mid-frame clears everything.
        pulse_reset();
        chk("t6_err_cleared", 64'(err), 64'd0);
        send(1'b0, 1'b0, dcnt); dcnt++;
        chk("t6_err_on_drop", 64'(err), 64'd1);
        stall = 1'b1;
        @(posedge clk);
        #2;
        cfg_skip = 3'd0; cfg_height = 10'd2;
        send(1'b1, 1'b0, dcnt); dcnt++;
        send(1'b0, 1'b0, dcnt); dcnt++;
        chk("t6_valid_before_rst", 64'(bus.m_valid), 64'd1);
        #2;
        chk_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_async_m_valid", 64'(bus.m_valid), 64'd0);
        chk("t6_async_m_flags", 64'({bus.m_sof, bus.m_eol, bus.m_eof}), 64'd0);
        chk("t6_async_m_data", 64'(bus.m_data), 64'd0);
        chk("t6_async_s_ready", 64'(bus.s_ready), 64'd0);
        chk("t6_async_err", 64'(err), 64'd0);
        stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_ready = 1'b1;
        chk("t6_release_s_ready", 64'(bus.s_ready), 64'd1);
        chk("t6_release_err", 64'(err), 64'd0);
        clear_q();

        // Test 7: one-beat frame, then height 0 treated as one kept line.
        send_frame(0, 1, 1, 1, 1'b1);
        send_frame(1, 0, 2, 2, 1'b0);
        drain_compare("t7");
        chk("t7_one_beat_flags", 64'(got_q[0][34:32]), 64'h7);
        chk("t7_eof_mask", 64'(mask(32)), 64'h0005);
        chk("t7_err", 64'(err), 64'd0);
        clear_q();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dwt_line_aligner.md
Name: dwt_line_aligner

Overview:
- Stream-side line aligner placed after the column DWT pipeline (two cascaded lifting units).
- Discards the configurable number of priming lines the lifting pipeline emits at the start of every frame, and regenerates SOF on the first kept beat.
- Marks the last beat of the frame with EOF, and reports framing errors.
- Generalises the hard-wired "skip 4 lines once after reset" logic:
  - skip depth is runtime-configurable;
  - the aligner re-arms on every frame;
  - data is multi-channel;
  - the output is registered with a skid buffer.

Parameters:
- DataWidth, 16, bits per coefficient.
- Channels, 1, parallel components per beat; each channel carries {high, low}.
- MaxSkipLines, 7, upper bound of cfg_skip_lines_i.
- MaxHeight, 512, maximum output lines per frame.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- cfg_skip_lines_i  in  $clog2(MaxSkipLines+1)  lines to drop per frame; sampled on the accepted SOF beat.
- cfg_height_i  in  $clog2(MaxHeight+1)  kept lines per frame; sampled on the accepted SOF beat; 0 is treated as 1.
- s_ready_o  out  1  upstream ready.
- s_valid_i  in  1  upstream valid.
- s_sof_i  in  1  first beat of input frame.
- s_eol_i  in  1  last beat of line.
- s_data_i  in  Channels*2*DataWidth  channel c occupies bits [c*2*DataWidth +: 2*DataWidth].
- m_ready_i  in  1  downstream ready.
- m_valid_o  out  1  downstream valid.
- m_sof_o  out  1  first kept beat of frame.
- m_eol_o  out  1  last beat of kept line.
- m_eof_o  out  1  last beat of last kept line.
- m_data_o  out  Channels*2*DataWidth  forwarded data, unmodified.
- err_o  out  1  sticky framing error; cleared only by reset.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all counters = 0; skid buffer empty.
  - m_valid_o, m_sof_o, m_eol_o, m_eof_o, err_o = 0; m_data_o = 0.
  - s_ready_o = 0 while rst_ni is low, 1 from the first cycle after release.
- A beat transfers when valid & ready; the same rule applies on both sides.
- States:
  - IDLE:
    - s_ready_o = 1.
    - Beat without s_sof_i: dropped, err_o <= 1.
    - Beat with s_sof_i: latch cfg values, line_cnt <= 0.
      - Latched skip > 0: go to SKIP and drop the beat (if s_eol_i also set, line_cnt <= 1; if skip == 1 go to PASS).
      - Latched skip == 0: go to PASS and forward the beat with m_sof.
  - SKIP:
    - s_ready_o = 1; every beat is dropped.
    - On an eol beat: line_cnt++. When line_cnt+1 == skip: line_cnt <= 0, go to PASS.
  - PASS:
    - s_ready_o = skid not full.
    - Each accepted beat is written to the skid buffer.
    - The first beat of the frame in PASS carries m_sof = 1; all others carry 0.
    - m_eol = s_eol_i.
    - m_eof = s_eol_i & (kept_cnt == height-1).
    - On an eol beat: kept_cnt++.
    - On the eof beat: go to IDLE.
- s_sof_i arriving in SKIP or PASS (not the frame's own first beat):
  - err_o <= 1; the frame aborts.
  - The beat is treated exactly as an IDLE SOF beat (re-latch cfg, restart).
  - Beats already in the skid buffer still drain unchanged.
  - No EOF is generated for the aborted frame.
- Skid buffer:
  - 2 entries.
  - Latency: 1 cycle from accepted input to m_valid_o.
  - Sustains 1 beat/cycle under continuous m_ready_i.
  - Output held stable while m_valid_o & ~m_ready_i.
- Counter widths:
  - line_cnt: $clog2(MaxSkipLines+1).
  - kept_cnt: $clog2(MaxHeight+1).
  - Neither counter wraps: the state transitions reset them first.
- Simultaneous s_sof_i & s_eol_i (one-beat line) is legal in every state.
- m_eof_o implies m_eol_o.

Decomposition:
- Package dwt_stream_pkg holds:
  - typedef state_t {IDLE, SKIP, PASS};
  - localparam default skip = 4, the value the 9/7 column pipeline requires.
- One sub-module, stream_skid_buffer:
  - parameter Width;
  - 2-entry, registered ready/valid;
  - carries {eof, eol, sof, data}.
- Column DWT top instantiates dwt_line_aligner with cfg_skip_lines_i tied to 4.

Test Plan:
- Channels=1, skip=4, height=3, 4-beat lines, 7 input lines, m_ready_i=1 -> first 16 beats dropped; 12 beats out at 1/cycle; m_sof on out beat 0; m_eol on beats 3, 7, 11; m_eof only on beat 11; err_o=0.
- skip=0, height=2, 2-beat lines -> input SOF beat forwarded with m_sof=1 one cycle after acceptance; m_eof on 4th output beat.
- Same stimulus as test 1 with random m_ready_i (50%) -> output beat sequence identical; no loss or duplication; data stable while stalled; s_ready_o low only when skid full.
- Two back-to-back frames, skip=4 then skip=2 (cfg changed between SOFs) -> second frame drops exactly 2 lines; second m_sof on its first kept beat.
- New s_sof_i mid-PASS after 1 kept line of height=3 -> err_o=1 next cycle; no m_eof for the aborted frame; new frame skips and aligns correctly.
- Beats in IDLE without SOF, then rst_ni pulsed low mid-frame -> err_o=1 on the first drop; during reset all outputs are 0 asynchronously; after release state is IDLE and err_o=0.
